// File: rtl/icache_refill_unit.sv
// icache_refill_unit: icache miss handler. Issues one block-aligned DRAM read,
// assembles the returned beats and presents the block as a one-cycle refill.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   miss_valid, miss_addr    icache miss and missing PC
//   flush                    backend recovery, cancels the refill
//   mem_req_*                read request to DRAM (valid/ready)
//   mem_resp_*               response beats (no back-pressure)
//   refill_*                 one-cycle block write to the icache
//   busy                     refill in progress
module icache_refill_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 64,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0] mem_resp_data,
  output logic                  refill_valid,
  output logic [ADDR_WIDTH-1:0] refill_addr,
  output logic [BLOCK_SIZE-1:0] refill_data,
  output logic                  busy
);

  localparam int NUM_BEATS   = BLOCK_SIZE / BEAT_WIDTH;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int CNT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cancel;
  logic [BLOCK_SIZE-1:0] r_data;

  logic                  w_accept;
  logic                  w_handshake;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_cancel;
  logic [ADDR_WIDTH-1:0] w_aligned;

  assign w_accept    = (r_state == S_IDLE) && miss_valid && !flush;
  assign w_handshake = (r_state == S_REQ) && !flush && mem_req_ready;
  assign w_beat      = (r_state == S_RESP) && mem_resp_valid;
  assign w_last      = w_beat && (r_cnt == LAST_BEAT);
  assign w_aligned   = miss_addr & ~OFF_MASK;

  // A flush landing on the final beat must also abandon the refill.
  assign w_cancel    = r_cancel || flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        if (flush)              w_next = S_IDLE;
        else if (mem_req_ready) w_next = S_RESP;
      end
      S_RESP: begin
        if (w_last) w_next = w_cancel ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    refill_valid  = 1'b0;
    busy          = 1'b0;
    unique case (r_state)
      S_IDLE: busy = 1'b0;
      S_REQ: begin
        mem_req_valid = 1'b1;
        busy          = 1'b1;
      end
      S_RESP: busy = 1'b1;
      S_DONE: begin
        refill_valid = !flush;
        busy         = 1'b1;
      end
    endcase
  end

  assign mem_req_addr = r_addr;
  assign refill_addr  = r_addr;
  assign refill_data  = r_data;

  // Beats outside RESP are protocol errors and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_cnt    <= '0;
      r_cancel <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= w_aligned;
        r_cancel <= 1'b0;
      end
      if (w_handshake) begin
        r_cnt <= '0;
      end
      if ((r_state == S_RESP) && flush) begin
        r_cancel <= 1'b1;
      end
      if (w_beat) begin
        r_data[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= mem_resp_data;
        if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
